// File: rtl/btpipe_out_buffer.sv
// Block-throttled FIFO feeding okBTPipeOut; ready only when a full block is servable.
// Optional statistics (underrun_count, max_level) built when BTPIPE_BUF_STATS_EN is defined.
module btpipe_out_buffer #(
    parameter int DEPTH_LOG2  = 10,
    parameter int BLOCK_WORDS = 256
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           in_data,
    input  logic                  pipe_out_read,
    input  logic                  pipe_out_blockstrobe,
    output logic [31:0]           pipe_out_data,
    output logic                  pipe_out_ready,
    output logic [DEPTH_LOG2:0]   level,
    output logic [15:0]           underrun_count,
    output logic [DEPTH_LOG2:0]   max_level
);

    localparam int LW = DEPTH_LOG2 + 1;
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [LW-1:0] FULL = LW'(DEPTH);
    localparam logic [LW-1:0] BLK = LW'(BLOCK_WORDS);

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    state_t                state, state_nx;
    logic [LW-1:0]         remaining, remaining_nx;
    logic [LW-1:0]         committed;
    logic signed [LW:0]    slack;
    logic                  ready_nx;
    logic [31:0]           mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic                  empty, wr_en, rd_en;

    assign in_ready = (level != FULL);
    assign empty    = (level == '0);
    assign wr_en    = in_valid & in_ready & ~flush;
    assign rd_en    = pipe_out_read & ~empty & ~flush;

    // Storage array; contents need no reset since level gates every read.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= in_data;
    end

    // Pointers and occupancy; full/empty come from level, not pointer equality.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            level <= level + {{(LW-1){1'b0}}, wr_en}
                           - {{(LW-1){1'b0}}, rd_en};
        end
    end

    // Read data register; holds last word across underruns and flushes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) pipe_out_data <= '0;
        else if (rd_en) pipe_out_data <= mem[rd_ptr];
    end

    // Block FSM and ready slack; underrun reads still consume the block.
    always_comb begin
        state_nx     = state;
        remaining_nx = remaining;
        if (flush) begin
            state_nx     = IDLE;
            remaining_nx = '0;
        end else if (pipe_out_blockstrobe) begin
            state_nx     = ACTIVE;
            remaining_nx = BLK;
        end else if (state == ACTIVE && pipe_out_read) begin
            remaining_nx = remaining - 1'b1;
            if (remaining == LW'(1)) state_nx = IDLE;
        end
        committed = (state == ACTIVE) ? remaining : '0;
        slack     = $signed({1'b0, level}) - $signed({1'b0, committed});
        ready_nx  = (slack >= $signed({1'b0, BLK}));
    end

    // Block state and registered ready flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            remaining      <= '0;
            pipe_out_ready <= 1'b0;
        end else begin
            state          <= state_nx;
            remaining      <= remaining_nx;
            pipe_out_ready <= flush ? 1'b0 : ready_nx;
        end
    end

`ifdef BTPIPE_BUF_STATS_EN
    logic          under;
    logic [15:0]   under_q;
    logic [LW-1:0] max_q;

    assign under = pipe_out_read & empty & ~flush;

    // Saturating underrun count and occupancy high-water mark; survive flush.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            under_q <= '0;
            max_q   <= '0;
        end else begin
            if (under && under_q != 16'hFFFF) under_q <= under_q + 1'b1;
            if (level > max_q) max_q <= level;
        end
    end

    assign underrun_count = under_q;
    assign max_level      = max_q;
`else
    assign underrun_count = '0;
    assign max_level      = '0;
`endif

endmodule

// File: doc/btpipe_out_buffer.md
# btpipe_out_buffer

Block-throttled output buffer between a streaming data producer (pattern generator, capture path) and the okBTPipeOut endpoint at 0xA0. It accepts 32-bit words on a valid/ready interface into an on-chip FIFO. It asserts `pipe_out_ready` only when a full host block can be served without stalling. It supplies read data with the one-cycle latency okBTPipeOut expects. Runs entirely in the okClk domain.

## Interface
- `DEPTH_LOG2`, 10: FIFO depth is 2^DEPTH_LOG2 words; must satisfy 2^DEPTH_LOG2 >= 2*BLOCK_WORDS.
- `BLOCK_WORDS`, 256: 32-bit words per host block (host block size in bytes / 4); power of two, >= 2.

Ports:
- `clk`  in  1  okClk; all logic rising-edge.
- `reset_n`  in  1  reset, asynchronous assert, active-low; deassertion synchronised externally to `clk`.
- `flush`  in  1  synchronous clear of FIFO contents and block state (from a WireIn bit).
- `in_valid`  in  1  producer word valid.
- `in_ready`  out  1  buffer can accept a word this cycle.
- `in_data`  in  32  producer word.
- `pipe_out_read`  in  1  from okBTPipeOut `ep_read`.
- `pipe_out_blockstrobe`  in  1  from okBTPipeOut `ep_blockstrobe`; one-cycle pulse before each block.
- `pipe_out_data`  out  32  to `ep_datain`.
- `pipe_out_ready`  out  1  to `ep_ready`.
- `level`  out  DEPTH_LOG2+1  current FIFO occupancy in words.
- `underrun_count`  out  16  reads issued while empty, saturating (stats option).
- `max_level`  out  DEPTH_LOG2+1  high-water mark of `level` (stats option).

## Operation
- Write: word stored when `in_valid && in_ready`. `in_ready = (level != 2^DEPTH_LOG2)`. Overflow is therefore impossible.
- Read: when `pipe_out_read` is high and `level != 0`, the head word is popped and registered onto `pipe_out_data`.
- Underrun: a read with `level == 0` holds `pipe_out_data` at its previous value and leaves `level` at 0. `underrun_count` increments, saturating at 0xFFFF.
- Simultaneous write and read while non-empty and non-full: `level` unchanged.
- Write and read in the same cycle while empty: the read is an underrun, and the written word is stored with no bypass.
- Block tracking, two-state FSM:
  - IDLE -> ACTIVE on `pipe_out_blockstrobe`. `remaining` loads BLOCK_WORDS.
  - In ACTIVE, each `pipe_out_read` decrements `remaining`; an underrun read also counts.
  - ACTIVE -> IDLE when `remaining` reaches 0.
  - A `pipe_out_blockstrobe` received while ACTIVE reloads `remaining` to BLOCK_WORDS and stays in ACTIVE.
- Ready rule: `committed = (state==ACTIVE) ? remaining : 0`. `pipe_out_ready` is high iff `level - committed >= BLOCK_WORDS`, with the subtraction done at DEPTH_LOG2+2 bits, signed. A negative result reads as not ready.
- Flush:
  - Takes priority over the same-cycle read and write.
  - `level`=0, pointers=0, state=IDLE, `remaining`=0, `pipe_out_ready`=0.
  - `pipe_out_data`, `underrun_count` and `max_level` are kept.
- Pointers wrap modulo 2^DEPTH_LOG2. The full/empty distinction comes from `level`, not from pointer equality.

## Timing
- Reset values: `pipe_out_data`=0, `pipe_out_ready`=0, `level`=0, `underrun_count`=0, `max_level`=0, state=IDLE. `in_ready`=1, since it derives from `level`.
- `in_ready` is combinational from registered `level`. A write at edge N is reflected in `level` after edge N.
- Read latency 1: with `pipe_out_read` high at edge N, `pipe_out_data` holds the popped word from after edge N until the next read.
- `pipe_out_ready` is registered and reflects `level`/state one cycle late. A word written at edge N affects `pipe_out_ready` after edge N+1.
- `reset_n` low mid-block aborts the block immediately. No partial state survives.
- Sustains one write and one read per cycle.

## Configuration
- `BTPIPE_BUF_STATS_EN` defined:
  - `underrun_count` and `max_level` are live.
  - `max_level` updates to `level` whenever `level > max_level`.
- Not defined:
  - Both outputs are tied to 0 and their registers are not built.
  - Underrun data and FSM behaviour are unchanged.

## Test plan
- Fill and ready: BLOCK_WORDS=256. Write 255 words, so `pipe_out_ready`=0. Write 1 more, so `pipe_out_ready`=1 two edges after that write, `level`=256.
- Block read: with 512 words of incrementing data 0..511, strobe then read 256. Requirements:
  - `pipe_out_data` = 0..255, each one edge after its read.
  - `pipe_out_ready` stays 1 throughout the block.
  - `level` ends at 256.
- Committed accounting: with 300 words stored, strobe and read 10. Requirements:
  - `pipe_out_ready`=0 during the block, since 290-246 < 256.
  - After the block ends, `level`=44 and `pipe_out_ready`=0.
- Full and underrun:
  - Writing 1024 words (DEPTH_LOG2=10) gives `in_ready`=0 and holds the 1025th word off.
  - Draining all 1024 then issuing 3 extra reads gives `underrun_count`=3 and `pipe_out_data` held at word 1023.
- Concurrent traffic: sustain in_valid=1 and pipe_out_read=1 at 100% for 10000 cycles starting from `level`=256. Requirements:
  - `level` is constant at 256.
  - The data sequence is intact.
  - `max_level`=256 with stats enabled, 0 with stats disabled.
- Flush and reset mid-block: pulse `flush` after 100 reads of a block. The next cycle shows `level`=0, `pipe_out_ready`=0, state=IDLE. Repeat the sequence with `reset_n` low: all outputs return to their reset values asynchronously.
